// File: rtl/drbg_pkg.sv
// Shared definitions for the DRBG sample reader: word width, slice count
// helper and the request FSM state encoding.
package drbg_pkg;

    localparam int DRBG_WORD_W = 128;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_CAPT = 1'b1;

    typedef enum logic {
        IDLE = S_IDLE,
        CAPT = S_CAPT
    } req_state_e;

    function automatic int slices_per_word(input int out_w);
        return DRBG_WORD_W / out_w;
    endfunction

endpackage

// File: rtl/sample_slicer.sv
// Active-word slicer: holds the word being drained, emits OUT_W-bit
// candidates LSB first and drops candidates outside the acceptance bound.
// Ports: clk/rst, flush, load/load_word (new word into act), out_ready,
// out_valid/out_data (sample stream), drained (act empty now or this cycle),
// empty (act_left==0), reject (candidate dropped this cycle).
module sample_slicer
    import drbg_pkg::*;
#(
    parameter int              OUT_W        = 8,
    parameter bit              REJECT_EN    = 1'b0,
    parameter longint unsigned REJECT_BOUND = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   load,
    input  logic [DRBG_WORD_W-1:0] load_word,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   drained,
    output logic                   empty,
    output logic                   reject
);

    localparam int SLICES = slices_per_word(OUT_W);
    localparam int LEFT_W = $clog2(SLICES + 1);
    localparam logic [OUT_W:0] BOUND = (OUT_W + 1)'(REJECT_BOUND);

    logic [DRBG_WORD_W-1:0] act;
    logic [LEFT_W-1:0]      act_left;
    logic [OUT_W-1:0]       cand;
    logic                   has;
    logic                   accept;
    logic                   consume;

    assign cand      = act[OUT_W-1:0];
    assign has       = act_left != '0;
    // One extra bit so a bound of 2^OUT_W accepts every value.
    assign accept    = !REJECT_EN || ({1'b0, cand} < BOUND);
    assign out_valid = has && accept;
    assign out_data  = cand;
    assign consume   = has && (!accept || out_ready);
    assign reject    = has && !accept && !flush;
    assign empty     = !has;
    assign drained   = !has || (act_left == LEFT_W'(1) && consume);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act      <= '0;
            act_left <= '0;
        end else if (flush) begin
            act_left <= '0;
        end else if (load) begin
            act      <= load_word;
            act_left <= LEFT_W'(SLICES);
        end else if (consume) begin
            act      <= act >> OUT_W;
            act_left <= act_left - LEFT_W'(1);
        end
    end

endmodule

// File: rtl/drbg_sample_reader.sv
// DRBG consumer: requests 128-bit words, keeps one word of prefetch and
// streams OUT_W-bit samples (optionally rejection-sampled) downstream.
// Ports: clk/rst, drbg_update/ready/shouldreset/randombits (DRBG side),
// flush, out_valid/out_ready/out_data (sample stream), exhausted,
// words_cnt/reject_cnt (saturating statistics).
module drbg_sample_reader
    import drbg_pkg::*;
#(
    parameter int              OUT_W        = 8,
    parameter bit              REJECT_EN    = 1'b0,
    parameter longint unsigned REJECT_BOUND = 256,
    parameter int              CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   drbg_update,
    input  logic                   drbg_ready,
    input  logic                   drbg_shouldreset,
    input  logic [DRBG_WORD_W-1:0] drbg_randombits,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   exhausted,
    output logic [CNT_W-1:0]       words_cnt,
    output logic [CNT_W-1:0]       reject_cnt
);

    req_state_e             state;
    req_state_e             state_nxt;
    logic [DRBG_WORD_W-1:0] spare;
    logic                   spare_v;
    logic                   inflight;
    logic                   capture;
    logic                   drained;
    logic                   act_empty;
    logic                   reject;
    logic                   load_act;
    logic [DRBG_WORD_W-1:0] load_word;

    assign inflight = state == CAPT;
    assign capture  = inflight && !flush;

    // A new word goes straight to act when act is (or is becoming) empty;
    // otherwise it parks in spare until act drains.
    assign load_act  = drained && (capture || spare_v);
    assign load_word = capture ? drbg_randombits : spare;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        drbg_update = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && !spare_v && drbg_ready &&
                    !drbg_shouldreset && !flush) begin
                    drbg_update = 1'b1;
                    state_nxt   = CAPT;
                end
            end
            CAPT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spare   <= '0;
            spare_v <= 1'b0;
        end else if (flush) begin
            spare_v <= 1'b0;
        end else if (capture && !drained) begin
            spare   <= drbg_randombits;
            spare_v <= 1'b1;
        end else if (spare_v && drained) begin
            spare_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_cnt  <= '0;
            reject_cnt <= '0;
            exhausted  <= 1'b0;
        end else begin
            if (capture && words_cnt != {CNT_W{1'b1}}) begin
                words_cnt <= words_cnt + CNT_W'(1);
            end
            if (reject && reject_cnt != {CNT_W{1'b1}}) begin
                reject_cnt <= reject_cnt + CNT_W'(1);
            end
            exhausted <= drbg_shouldreset && !inflight &&
                         !spare_v && act_empty;
        end
    end

    sample_slicer #(
        .OUT_W        (OUT_W),
        .REJECT_EN    (REJECT_EN),
        .REJECT_BOUND (REJECT_BOUND)
    ) u_slicer (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (load_act),
        .load_word (load_word),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .drained   (drained),
        .empty     (act_empty),
        .reject    (reject)
    );

endmodule

// File: tb/tb_drbg_sample_reader.sv
// Bench for drbg_sample_reader: an 8-bit plain instance and a 4-bit
// rejection instance, each checked against a queue model every cycle.
module tb_drbg_sample_reader;

    localparam int SLA  = 16;
    localparam int SLB  = 32;
    localparam int BNDA = 256;
    localparam int BNDB = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_upd, a_rdy, a_sr, a_flush, a_ov, a_or, a_exh;
    logic [127:0] a_bits = '0;
    logic [7:0]   a_od;
    logic [31:0]  a_wc, a_rc;

    logic         b_upd, b_rdy, b_sr, b_flush, b_ov, b_or, b_exh;
    logic [127:0] b_bits = '0;
    logic [3:0]   b_od;
    logic [3:0]   b_wc, b_rc;

    drbg_sample_reader #(
        .OUT_W(8), .REJECT_EN(1'b0), .REJECT_BOUND(256), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst(rst),
        .drbg_update(a_upd), .drbg_ready(a_rdy),
        .drbg_shouldreset(a_sr), .drbg_randombits(a_bits),
        .flush(a_flush), .out_valid(a_ov), .out_ready(a_or),
        .out_data(a_od), .exhausted(a_exh),
        .words_cnt(a_wc), .reject_cnt(a_rc)
    );

    drbg_sample_reader #(
        .OUT_W(4), .REJECT_EN(1'b1), .REJECT_BOUND(10), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .drbg_update(b_upd), .drbg_ready(b_rdy),
        .drbg_shouldreset(b_sr), .drbg_randombits(b_bits),
        .flush(b_flush), .out_valid(b_ov), .out_ready(b_or),
        .out_data(b_od), .exhausted(b_exh),
        .words_cnt(b_wc), .reject_cnt(b_rc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] mkword(input logic [7:0] base);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    // DRBG sources: a word appears the cycle after update && ready.
    logic [127:0] srca[$];
    logic [127:0] srcb[$];

    always @(posedge clk) begin
        if (a_upd && a_rdy) a_bits <= (srca.size() != 0) ? srca.pop_front() : '0;
        if (b_upd && b_rdy) b_bits <= (srcb.size() != 0) ? srcb.pop_front() : '0;
    end

    // Model: a queue of every slice not yet consumed (active word + prefetch).
    logic [7:0]  qa[$];
    logic [3:0]  qb[$];
    logic        pa, pb, exa, exb;
    logic [31:0] wca, rca;
    logic [3:0]  wcb, rcb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete(); pa <= 1'b0; wca <= '0; rca <= '0; exa <= 1'b0;
        end else begin
            exa <= a_sr && !pa && qa.size() == 0;
            if (a_flush) begin
                qa.delete();
            end else begin
                if (qa.size() != 0) begin
                    if (int'(qa[0]) >= BNDA) begin
                        if (rca != '1) rca <= rca + 1;
                        void'(qa.pop_front());
                    end else if (a_or) begin
                        void'(qa.pop_front());
                    end
                end
                if (pa) begin
                    for (int i = 0; i < SLA; i++) qa.push_back(a_bits[i*8 +: 8]);
                    if (wca != '1) wca <= wca + 1;
                end
            end
            pa <= a_upd && a_rdy;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qb.delete(); pb <= 1'b0; wcb <= '0; rcb <= '0; exb <= 1'b0;
        end else begin
            exb <= b_sr && !pb && qb.size() == 0;
            if (b_flush) begin
                qb.delete();
            end else begin
                if (qb.size() != 0) begin
                    if (int'(qb[0]) >= BNDB) begin
                        if (rcb != '1) rcb <= rcb + 1;
                        void'(qb.pop_front());
                    end else if (b_or) begin
                        void'(qb.pop_front());
                    end
                end
                if (pb) begin
                    for (int i = 0; i < SLB; i++) qb.push_back(b_bits[i*4 +: 4]);
                    if (wcb != '1) wcb <= wcb + 1;
                end
            end
            pb <= b_upd && b_rdy;
        end
    end

    // Compare process: the prefetch slot is free iff at most one word of
    // slices is outstanding.
    always @(negedge clk) begin
        chk("a_upd", a_upd, !rst && a_rdy && !a_sr && !a_flush && !pa &&
                            qa.size() <= SLA);
        chk("a_ov", a_ov, qa.size() != 0 && int'(qa[0]) < BNDA);
        if (a_ov && qa.size() != 0) chk("a_od", a_od, qa[0]);
        chk("a_wc", a_wc, wca);
        chk("a_rc", a_rc, rca);
        chk("a_exh", a_exh, exa);
        chk("b_upd", b_upd, !rst && b_rdy && !b_sr && !b_flush && !pb &&
                            qb.size() <= SLB);
        chk("b_ov", b_ov, qb.size() != 0 && int'(qb[0]) < BNDB);
        if (b_ov && qb.size() != 0) chk("b_od", b_od, qb[0]);
        chk("b_wc", b_wc, wcb);
        chk("b_rc", b_rc, rcb);
        chk("b_exh", b_exh, exb);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_a(input logic [7:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!(a_ov && a_or) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("take_a_timeout", 1'b0, 1'b1);
        else chk("take_a", a_od, v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_rdy = 0; a_sr = 0; a_flush = 0; a_or = 0;
        b_rdy = 0; b_sr = 0; b_flush = 0; b_or = 1;
        #12;
        chk("rst_a_upd", a_upd, 0);
        chk("rst_a_ov", a_ov, 0);
        chk("rst_a_od", a_od, 0);
        chk("rst_a_exh", a_exh, 0);
        chk("rst_a_wc", a_wc, 0);
        chk("rst_a_rc", a_rc, 0);
        chk("rst_b_ov", b_ov, 0);
        chk("rst_b_rc", b_rc, 0);
        tick(); tick();
        rst = 1'b0;

        // Single word, streamed 00..0F back to back.
        srca.push_back(mkword(8'h00));
        a_or = 1;
        tick();
        a_rdy = 1;
        @(negedge clk);
        chk("t1_upd", a_upd, 1);
        tick();
        a_rdy = 0;
        @(negedge clk);
        chk("t1_capt_upd", a_upd, 0);
        chk("t1_capt_ov", a_ov, 0);
        chk("t1_wc0", a_wc, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t1_ov", a_ov, 1);
            chk("t1_od", a_od, 8'(i));
        end
        @(negedge clk);
        chk("t1_wc", a_wc, 1);
        chk("t1_empty", a_ov, 0);

        // Two words, no gap at the boundary; second request while draining.
        srca.push_back(mkword(8'h10));
        srca.push_back(mkword(8'h20));
        tick();
        a_rdy = 1;
        fork
            begin
                int k, nup;
                k = 0; nup = 0;
                while (nup < 2 && k < 40) begin
                    @(negedge clk);
                    if (a_upd) nup++;
                    k++;
                end
                chk("t2_two_req", nup, 2);
                chk("t2_req_mid_drain", a_ov, 1);
                tick();
                a_rdy = 0;
            end
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (!a_ov && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                for (int i = 0; i < 32; i++) begin
                    chk("t2_ov", a_ov, 1);
                    chk("t2_od", a_od, 8'(8'h10 + i));
                    @(negedge clk);
                end
            end
        join
        chk("t2_wc", a_wc, 3);

        // Consumer stalls for 5 cycles mid-word.
        srca.push_back(mkword(8'h30));
        tick();
        a_rdy = 1;
        @(negedge clk);
        chk("t4_req", a_upd, 1);
        tick();
        a_rdy = 0;
        for (int i = 0; i < 4; i++) take_a(8'(8'h30 + i));
        tick();
        a_or = 0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_v", a_ov, 1);
            chk("t4_hold_d", a_od, 8'h34);
        end
        tick();
        a_or = 1;
        for (int i = 4; i < 16; i++) take_a(8'(8'h30 + i));

        // Reseed limit with three slices left.
        srca.push_back(mkword(8'h40));
        srca.push_back(mkword(8'h50));
        srca.push_back(mkword(8'h60));
        srca.push_back(mkword(8'h70));
        tick();
        a_rdy = 1;
        @(negedge clk);
        chk("t5_req", a_upd, 1);
        tick();
        a_rdy = 0;
        for (int i = 0; i < 13; i++) take_a(8'(8'h40 + i));
        tick();
        a_or = 0; a_sr = 1; a_rdy = 1;
        repeat (4) begin
            @(negedge clk);
            chk("t5_no_req", a_upd, 0);
            chk("t5_not_exh", a_exh, 0);
        end
        tick();
        a_or = 1;
        for (int i = 13; i < 16; i++) take_a(8'(8'h40 + i));
        @(negedge clk);
        @(negedge clk);
        chk("t5_exh", a_exh, 1);
        tick();
        a_sr = 0;
        @(negedge clk);
        chk("t5_resume", a_upd, 1);
        @(negedge clk);
        chk("t5_exh_clr", a_exh, 0);

        // Flush during the capture cycle of the prefetch request.
        @(negedge clk);
        chk("t6_prefetch_req", a_upd, 1);
        tick();
        a_flush = 1; a_rdy = 0;
        tick();
        a_flush = 0;
        @(negedge clk);
        chk("t6_ov_after_flush", a_ov, 0);
        chk("t6_wc", a_wc, 6);
        tick();
        a_rdy = 1;
        @(negedge clk);
        chk("t6_fresh_req", a_upd, 1);
        tick();
        a_rdy = 0;
        take_a(8'h70);
        take_a(8'h71);

        // Asynchronous reset mid-drain.
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("t7_ov", a_ov, 0);
        chk("t7_od", a_od, 0);
        chk("t7_upd", a_upd, 0);
        chk("t7_wc", a_wc, 0);
        chk("t7_rc", a_rc, 0);
        chk("t7_exh", a_exh, 0);
        tick();
        rst = 0;

        // 4-bit rejection sampling, bound 10: slices 3,A,5,F then zeros.
        srcb.push_back(128'h0000F5A3);
        srcb.push_back({128{1'b1}});
        tick();
        b_rdy = 1;
        @(negedge clk);
        chk("b_req", b_upd, 1);
        tick();
        b_rdy = 0;
        @(negedge clk);
        begin
            int acc;
            logic [3:0] ev;
            acc = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                ev = (i == 0) ? 4'h3 : (i == 1) ? 4'hA :
                     (i == 2) ? 4'h5 : (i == 3) ? 4'hF : 4'h0;
                chk("b_slot_ov", b_ov, ev < 4'hA);
                if (b_ov) begin
                    acc++;
                    chk("b_slot_od", b_od, ev);
                end
            end
            chk("b_accepted", acc, 30);
        end
        @(negedge clk);
        chk("b_rc2", b_rc, 2);
        chk("b_wc1", b_wc, 1);

        // A word of all-F slices: every one rejected, counter saturates.
        tick();
        b_rdy = 1;
        @(negedge clk);
        chk("b_req2", b_upd, 1);
        tick();
        b_rdy = 0;
        repeat (40) begin
            @(negedge clk);
            chk("b_all_rej_ov", b_ov, 0);
        end
        chk("b_rc_sat", b_rc, 4'hF);
        chk("b_wc2", b_wc, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/drbg_sample_reader.md
Name: drbg_sample_reader

Overview:
- Consumer end of the DRBG output handshake (`update`/`ready`/`randombits`/`shouldreset`).
- Pulls 128-bit random words from the AES-CTR DRBG and slices them into OUT_W-bit samples, LSB first.
- Optionally rejection-samples against a bound.
- Delivers samples on a valid/ready stream to the signing/keygen datapath (e.g. GF(16)/GF(256) element generation).
- Keeps a one-word prefetch so a ready consumer sees no gaps.

Parameters:
- OUT_W, 8, sample width in bits; legal values 1, 2, 4, 8, 16, 32, 64, 128 (must divide 128).
- REJECT_EN, 0, 1 = drop samples with value >= REJECT_BOUND.
- REJECT_BOUND, 256, exclusive acceptance bound; used only when REJECT_EN=1; must satisfy 1 <= REJECT_BOUND <= 2^OUT_W.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- drbg_update  out  1  word request to DRBG
- drbg_ready  in  1  DRBG has a word available
- drbg_shouldreset  in  1  DRBG reseed limit reached
- drbg_randombits  in  128  DRBG word; valid the cycle after `drbg_update && drbg_ready`
- flush  in  1  synchronous discard of all buffered and in-flight bits
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts sample
- out_data  out  OUT_W  sample value
- exhausted  out  1  no more samples obtainable until DRBG reseed
- words_cnt  out  CNT_W  words captured since reset (saturating)
- reject_cnt  out  CNT_W  samples rejected since reset (saturating)

Behaviour:
- Reset (async, rst=1): all of the following clear to 0 — `drbg_update`, `out_valid`, `out_data`, `exhausted`, both counters, buffer flags, slice counts.
- Storage:
  - `act`: 128-bit shift register with `act_left` (0..128/OUT_W slices remaining).
  - `spare`: 128-bit register with `spare_v` flag.
  - `inflight` flag.
- Request FSM:
  - IDLE: if `!spare_v && !inflight && drbg_ready && !drbg_shouldreset && !flush`, assert `drbg_update` (combinationally from registered state and inputs, one cycle) and go to CAPT. The request is counted as issued only when `drbg_ready` is high in that same cycle.
  - CAPT: `inflight=1`; next cycle, latch `drbg_randombits`, increment `words_cnt`, return to IDLE.
    - If `act_left==0` (or becomes 0 this cycle), load `act` directly and set `act_left=128/OUT_W`.
    - Otherwise load `spare` and set `spare_v=1`.
  - Never more than one request in flight.
  - `drbg_update` is never asserted while `drbg_ready=0`.
- Slicing:
  - Candidate sample = `act[OUT_W-1:0]` whenever `act_left>0`.
  - Accept = `!REJECT_EN || candidate < REJECT_BOUND`, using an unsigned compare in OUT_W+1 bits.
  - `out_valid = act_left>0 && accept`; `out_data = candidate` (combinational from `act`).
  - Consume the candidate (shift `act` right by OUT_W, decrement `act_left`) when `(out_valid && out_ready)` or `(act_left>0 && !accept)`.
  - A rejected candidate is dropped in one cycle with `out_valid=0`, and `reject_cnt` increments.
  - When `act_left` reaches 0 and `spare_v=1`, `spare` moves to `act` in the same cycle: `act_left` is reloaded and `spare_v` clears. Sustained throughput is therefore 1 accepted sample/cycle.
- `out_valid`/`out_data` are stable while `out_valid && !out_ready`; the standard valid/ready rule applies.
- `flush`:
  - Highest priority.
  - Clears `act_left`, `spare_v` and `inflight`.
  - A capture due in the flush cycle is suppressed and not counted.
  - `drbg_update=0` during flush.
- `exhausted = drbg_shouldreset && !inflight && !spare_v && act_left==0`; it is a registered output, updated one cycle after the condition.
- Counters saturate at all-ones and do not wrap.
- Rejection with `REJECT_BOUND = 2^OUT_W` behaves identically to `REJECT_EN=0`.

Decomposition:
- Shared package `drbg_pkg`:
  - `DRBG_WORD_W = 128`
  - the slices-per-word function `128/OUT_W`
  - FSM state encoding localparams: IDLE, CAPT
- One natural sub-module, `sample_slicer`:
  - contents: `act` register, `act_left` counter, reject compare, spare-to-act transfer.
  - parent contents: DRBG handshake, prefetch, counters, flush.

Test Plan:
- OUT_W=8, DRBG supplies word `128'h0F0E0D0C0B0A09080706050403020100`, `out_ready=1`:
  - `drbg_update` pulses once, capture follows the next cycle.
  - `out_data` = 00,01,…,0F on 16 consecutive cycles.
  - `words_cnt=1` after the capture.
- Back-to-back words W0, W1 with `out_ready=1`: 32 samples with no `out_valid` gap at the word boundary. The second request is issued while the first word is still draining.
- OUT_W=4, REJECT_EN=1, REJECT_BOUND=10, word `128'h…0000F5A3`:
  - Accepted outputs are 3, 5, then 28 zeros (30 accepted in total).
  - `reject_cnt=2`.
  - `out_valid` is low in the A and F candidate cycles.
- `out_ready` held low for 5 cycles mid-word: `out_data` is held constant, then the sequence continues with no sample lost or duplicated.
- `drbg_shouldreset=1` with `act_left=3`, `spare_v=0`:
  - No further `drbg_update`.
  - After 3 handshakes, `exhausted=1` on the next cycle.
  - Deasserting `shouldreset` clears `exhausted` and requests resume.
- `flush` asserted in the CAPT cycle:
  - Capture is suppressed and `words_cnt` is unchanged.
  - `out_valid=0` the next cycle.
  - A fresh request follows.
  - Async `rst` mid-drain zeroes all outputs immediately.
